// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit for the single-cycle RV32I core.
// Takes the effective address from the ALU and rs2 store data. Runs one access
// over a req/gnt/rvalid data-memory bus. Returns aligned, sign/zero-extended
// load data to writeback, and stalls the core while the access is in flight.
//
// Optional feature macro: LSU_TIMEOUT_EN. When defined, a bus watchdog aborts
// an access after TIMEOUT_CYCLES cycles in REQ/WAIT and flags o_bus_err.
//
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_lsu_req/we/funct3   core-side request (held until o_lsu_done)
//   i_alu_data            effective byte address
//   i_rs2_data            store data
//   o_stall               combinational core freeze
//   o_lsu_done            one-cycle completion pulse
//   o_ld_data             extended load result (valid with o_lsu_done)
//   o_misalign, o_bus_err completion flags
//   o_mem_* / i_mem_*     data-memory bus
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_lsu_req,
  input  logic        i_lsu_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_alu_data,
  input  logic [31:0] i_rs2_data,
  output logic        o_stall,
  output logic        o_lsu_done,
  output logic [31:0] o_ld_data,
  output logic        o_misalign,
  output logic        o_bus_err,
  output logic        o_mem_req,
  input  logic        i_mem_gnt,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        lane_q, lane_d;

  logic              done_q, done_d;
  logic [XLEN-1:0]   ld_data_q, ld_data_d;
  logic              misalign_q, misalign_d;
  logic              bus_err_q, bus_err_d;
  logic              mem_req_q, mem_req_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;

  logic              legal_c;
  logic              misalign_c;
  logic [BE_W-1:0]   be_c;
  logic [XLEN-1:0]   wdata_c;
  logic [7:0]        ld_byte_c;
  logic [15:0]       ld_half_c;
  logic [XLEN-1:0]   ld_ext_c;
  logic              timeout_c;

  // Bus watchdog: cleared while idle, counts every cycle spent in REQ/WAIT.
`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
    end else if (state_q == REQ || state_q == WAIT) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
`else
  logic unused_timeout;

  assign timeout_c      = 1'b0;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

  // Request decode: legality, alignment, byte enables, lane-replicated data.
  always_comb begin : decode
    legal_c    = 1'b0;
    misalign_c = 1'b0;
    be_c       = 4'b1111;
    wdata_c    = i_rs2_data;

    // Stores allow B/H/W only; loads additionally allow BU/HU.
    if (i_lsu_we) begin
      legal_c = !i_funct3[2] && (i_funct3[1:0] != 2'b11);
    end else begin
      legal_c = (i_funct3[1:0] != 2'b11) && !(i_funct3[2] && i_funct3[1]);
    end

    case (i_funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << i_alu_data[1:0];
        wdata_c = {4{i_rs2_data[7:0]}};
      end
      2'b01: begin
        misalign_c = i_alu_data[0];
        be_c       = i_alu_data[1] ? 4'b1100 : 4'b0011;
        wdata_c    = {2{i_rs2_data[15:0]}};
      end
      default: begin
        misalign_c = |i_alu_data[1:0];
      end
    endcase

    // An illegal funct3 is a silent no-op, never a misalign.
    misalign_c = misalign_c && legal_c;
  end

  // Load lane selection and extension from the captured request context.
  always_comb begin : extract
    ld_byte_c = 8'(i_mem_rdata >> {lane_q, 3'b000});
    ld_half_c = lane_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    ld_ext_c  = '0;
    if (!we_q) begin
      case (funct3_q)
        3'b000:  ld_ext_c = {{24{ld_byte_c[7]}}, ld_byte_c};
        3'b001:  ld_ext_c = {{16{ld_half_c[15]}}, ld_half_c};
        3'b010:  ld_ext_c = i_mem_rdata;
        3'b100:  ld_ext_c = {24'd0, ld_byte_c};
        3'b101:  ld_ext_c = {16'd0, ld_half_c};
        default: ld_ext_c = '0;
      endcase
    end
  end

  // Next-state and next-output logic.
  always_comb begin : fsm_next
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    lane_d      = lane_q;
    done_d      = 1'b0;
    ld_data_d   = '0;
    misalign_d  = 1'b0;
    bus_err_d   = 1'b0;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (i_lsu_req) begin
          we_d     = i_lsu_we;
          funct3_d = i_funct3;
          lane_d   = i_alu_data[1:0];
          if (!legal_c || misalign_c) begin
            state_d    = DONE;
            done_d     = 1'b1;
            misalign_d = misalign_c;
          end else begin
            state_d     = REQ;
            mem_req_d   = 1'b1;
            mem_addr_d  = {i_alu_data[31:2], 2'b00};
            mem_we_d    = i_lsu_we;
            mem_be_d    = be_c;
            mem_wdata_d = wdata_c;
          end
        end
      end
      REQ: begin
        // A grant in the same cycle as the watchdog expiring wins.
        if (i_mem_gnt) begin
          state_d   = WAIT;
          mem_req_d = 1'b0;
        end else if (timeout_c) begin
          state_d   = DONE;
          done_d    = 1'b1;
          bus_err_d = 1'b1;
          mem_req_d = 1'b0;
        end
      end
      WAIT: begin
        if (i_mem_rvalid) begin
          state_d   = DONE;
          done_d    = 1'b1;
          ld_data_d = ld_ext_c;
        end else if (timeout_c) begin
          state_d   = DONE;
          done_d    = 1'b1;
          bus_err_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      lane_q      <= '0;
      done_q      <= 1'b0;
      ld_data_q   <= '0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      lane_q      <= lane_d;
      done_q      <= done_d;
      ld_data_q   <= ld_data_d;
      misalign_q  <= misalign_d;
      bus_err_q   <= bus_err_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // The core may advance in DONE even though it still holds its request.
  assign o_stall     = i_lsu_req && (state_q != DONE);
  assign o_lsu_done  = done_q;
  assign o_ld_data   = ld_data_q;
  assign o_misalign  = misalign_q;
  assign o_bus_err   = bus_err_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_be    = mem_be_q;
  assign o_mem_wdata = mem_wdata_q;

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit for the single-cycle RV32I core, sitting directly downstream of the ALU.
- Takes the effective address from `o_alu_data` plus `rs2` store data, and performs the access over a req/gnt/rvalid data-memory bus.
- Returns aligned, sign/zero-extended load data to the writeback mux.
- Holds the core via a stall signal while an access is in flight.
- Replaces the combinational data-memory path so the core can use variable-latency memory.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: bus watchdog limit in cycles. Used only with `LSU_TIMEOUT_EN`.

Ports:
- `i_clk`  in  1  clock. One clock domain; all state is on its rising edge.
- `i_rst_n`  in  1  reset. Asynchronous, active-low.
- `i_lsu_req`  in  1  current instruction is a load/store; held by the core until the cycle `o_lsu_done` is high.
- `i_lsu_we`  in  1  1 = store, 0 = load.
- `i_funct3`  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `i_alu_data`  in  32  effective byte address.
- `i_rs2_data`  in  32  store data.
- `o_stall`  out  1  freeze PC/regfile; combinational, `i_lsu_req & (state != DONE)`.
- `o_lsu_done`  out  1  one-cycle completion pulse.
- `o_ld_data`  out  32  extended load result; valid while `o_lsu_done` is high.
- `o_misalign`  out  1  pulse with `o_lsu_done` on a misaligned access.
- `o_bus_err`  out  1  pulse with `o_lsu_done` on a watchdog timeout.
- `o_mem_req`  out  1  bus request.
- `i_mem_gnt`  in  1  bus accepted the request this cycle.
- `o_mem_addr`  out  32  word address, `{addr[31:2],2'b00}`.
- `o_mem_we`  out  1  write.
- `o_mem_be`  out  4  byte enables.
- `o_mem_wdata`  out  32  lane-replicated store data.
- `i_mem_rvalid`  in  1  read data / write ack.
- `i_mem_rdata`  in  32  read word.

## Operation
FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE:** when `i_lsu_req` is high, register addr, we, funct3, be and wdata.
  - Aligned legal access → REQ.
  - Misaligned access (H/HU/SH with `addr[0]`=1; W/SW with `addr[1:0]`≠0) → DONE, set `o_misalign`, no bus transaction.
  - Illegal funct3 (loads 011/110/111; stores >010) → DONE as a no-op: no bus transaction, no flag.
- **REQ:** `o_mem_req`=1, with addr/we/be/wdata stable until `i_mem_gnt`; then → WAIT.
- **WAIT:** on `i_mem_rvalid`, capture extended data → DONE. Stores also wait for `i_mem_rvalid` as the write ack.
- **DONE:** `o_lsu_done`=1 and `o_stall`=0, so the core advances; → IDLE unconditionally.

Byte enables and store data:
- SB: `be=4'b0001<<addr[1:0]`, `wdata={4{rs2[7:0]}}`.
- SH: `be = addr[1] ? 4'b1100 : 4'b0011`, `wdata={2{rs2[15:0]}}`.
- SW: `be=4'b1111`, `wdata=rs2`.
- Loads drive the same be pattern.

Load extraction:
- Select the byte/halfword lane by `addr[1:0]`.
- B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- `o_ld_data`=0 on misalign, illegal funct3, timeout and store.

Boundary rules:
- `i_mem_rvalid` in IDLE/REQ/DONE is ignored.
- `i_mem_rvalid` may not arrive in the same cycle as `i_mem_gnt`; the earliest is the next cycle.
- `i_lsu_req` dropping mid-access does not abort the access; it completes.
- Reset mid-access → IDLE immediately; `o_mem_req` drops asynchronously; a late `i_mem_rvalid` is ignored.

## Timing
- Reset values: state IDLE, and `o_lsu_done`, `o_ld_data`, `o_misalign`, `o_bus_err`, `o_mem_req`, `o_mem_addr`, `o_mem_we`, `o_mem_be`, `o_mem_wdata` all 0. `o_stall` follows `i_lsu_req`.
- Request seen in cycle C (IDLE) → `o_mem_req` in C+1.
- With `gnt` in C+1 and `rvalid` in C+2: DONE in C+3. Minimum stall is 3 cycles; the instruction retires in C+3.
- Each cycle of `gnt`/`rvalid` delay adds one cycle.
- Misaligned/illegal: DONE in C+1.
- All outputs except `o_stall` are registered.

## Configuration
- `LSU_TIMEOUT_EN` defined: a counter is cleared on IDLE→REQ and increments each cycle in REQ/WAIT.
  - On reaching `TIMEOUT_CYCLES`, the FSM moves → DONE with `o_bus_err`=1 and `o_ld_data`=0.
  - `o_mem_req` drops, and a late `rvalid` is ignored.
- Undefined: no counter; `o_bus_err` is tied 0 and the FSM waits indefinitely.

## Test plan
- LW addr 0x1000, gnt immediate, rvalid next with 0xDEADBEEF → `o_mem_addr`=0x1000, `be`=1111, `o_ld_data`=0xDEADBEEF, done at C+3.
- LB addr 0x1003, rdata 0x80123456 → `be`=1000, `o_ld_data`=0xFFFFFF80. Same with LBU → 0x00000080.
- LHU addr 0x2002, rdata 0xBEEF1234 → 0x0000BEEF. LH → 0xFFFFBEEF.
- SB addr 0x11, rs2 0x123456A5 → `o_mem_addr`=0x10, `be`=0010, `wdata`=0xA5A5A5A5, `we`=1. SH addr 0x12 → `be`=1100, `wdata`=0x56A556A5.
- LW addr 0x1002 → no `o_mem_req`, `o_misalign` + `o_lsu_done` at C+1, `o_ld_data`=0. Gnt held low 3 cycles → addr/be stable; done at C+6.
- With `LSU_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, no gnt → `o_bus_err` + done after 8 cycles in REQ. Separately, `i_rst_n` pulsed in WAIT → outputs zero, IDLE, late rvalid ignored.
